alu_op_issuer: RTL and testbench
================================

// Module: alu_op_issuer
// PURPOSE
//  Instruction-side producer for the ALU opcode map: fetches 9-bit words from a
//  synchronous instruction ROM, decodes them, and issues 4-bit ALU opcodes plus a
//  5-bit immediate over a valid/ready handshake. Handles control-flow opcodes
//  (BRZ/JMP/HALT) locally using the ALU zero flag. Sits between imem and the ALU.
// PARAMETERS
//  PC_W        8     program counter / imem address width
//  START_ADDR  0     PC value loaded on reset and on every accepted start
//  CNT_W       16    width of issued-op counter (saturating)
// PORTS
//  clk           in   1      clock, all state updates on rising edge
//  reset         in   1      synchronous, active-high
//  start         in   1      pulse; begins execution at START_ADDR when idle/halted
//  imem_addr     out  PC_W   instruction address (= pc)
//  imem_data     in   9      instruction word, valid 1 cycle after imem_addr is driven
//  alu_valid     out  1      opcode/immediate presented to the ALU
//  alu_ready     in   1      ALU accepts the op when alu_valid && alu_ready
//  alu_op        out  4      ALU opcode (0000..1100 per the ALU instruction map)
//  alu_imm       out  5      immediate field accompanying alu_op
//  alu_zero      in   1      zero flag of the most recently completed ALU op
//  busy          out  1      high in FETCH/DECODE/ISSUE
//  halted        out  1      high in HALTED
//  pc            out  PC_W   current program counter
//  issued_count  out  CNT_W  number of ALU ops accepted since last start
// BEHAVIOUR
//  Instruction word: [8:5] opcode, [4:0] imm. Opcodes 0000..1100 are ALU ops;
//   1101 BRZ, 1110 JMP, 1111 HALT are consumed locally, never sent to the ALU.
//  Reset: state IDLE, pc=START_ADDR, alu_valid=0, alu_op=0000, alu_imm=0,
//   busy=0, halted=0, issued_count=0. Reset overrides everything, incl. mid-issue.
//  FSM states: IDLE, FETCH, DECODE, ISSUE, HALTED.
//   IDLE/HALTED: start=1 -> pc<=START_ADDR, issued_count<=0, -> FETCH. Else hold.
//   FETCH: imem_addr=pc; -> DECODE unconditionally (one-cycle ROM latency).
//   DECODE: sample imem_data.
//     ALU op -> register alu_op/alu_imm, alu_valid<=1, -> ISSUE.
//     BRZ    -> pc <= alu_zero ? pc+sext(imm) : pc+1; -> FETCH.
//     JMP    -> pc <= pc+sext(imm); -> FETCH.
//     HALT   -> pc unchanged; -> HALTED.
//   ISSUE: alu_valid, alu_op, alu_imm held stable until alu_ready. On handshake:
//     alu_valid<=0, pc<=pc+1, issued_count+1 (saturates at all-ones), -> FETCH.
//  start ignored in FETCH/DECODE/ISSUE. alu_op/alu_imm keep last issued value
//   while alu_valid=0.
//  Latency: ALU op minimum 3 cycles per instruction (FETCH, DECODE, ISSUE with
//   ready=1); BRZ/JMP 2 cycles; HALT reaches HALTED 2 cycles after FETCH.
//  Arithmetic: sext(imm) is 5-bit two's complement (-16..+15) extended to PC_W;
//   all pc updates wrap modulo 2^PC_W (pc=all-ones +1 -> 0).
//  alu_zero is sampled only in DECODE of BRZ; the ALU holds it from completion
//   of the previous op, which is guaranteed at least 2 cycles earlier.
//  busy/halted/pc are registered state decodes; imem_addr = pc combinationally.
// TESTING
//  1 reset, start; ROM[0]=0101_00011 (ADD,3), ROM[1]=1111 -> alu_valid rises 2
//    cycles after FETCH with op=0101 imm=3; ready=1 -> HALTED, issued_count=1.
//  2 ALU stall: hold alu_ready=0 for 5 cycles -> alu_valid/op/imm stable all 5,
//    pc and issued_count unchanged; accepted on cycle ready rises.
//  3 BRZ at pc=4 imm=11110 (-2): alu_zero=1 -> next fetch addr 2; alu_zero=0 -> 5.
//  4 PC_W=8, JMP at pc=255 imm=00001 -> pc=0; ALU op at 255 accepted -> pc=0.
//  5 reset asserted in ISSUE with alu_valid=1 -> next cycle alu_valid=0, IDLE,
//    pc=START_ADDR, issued_count=0; start in ISSUE has no effect.
//  6 CNT_W=2, four ALU ops then HALT -> issued_count saturates at 3; start from
//    HALTED restarts at START_ADDR with issued_count=0.

Source files
------------

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: fetches 9-bit instruction words from a synchronous ROM,
// issues ALU opcodes with a 5-bit immediate over valid/ready, and resolves
// BRZ/JMP/HALT locally using the ALU zero flag.
//
// state    | meaning
// S_IDLE   | waiting for start after reset
// S_FETCH  | imem_addr = pc, ROM word arrives next cycle
// S_DECODE | ROM word valid; dispatch ALU op or resolve control flow
// S_ISSUE  | alu_valid held with stable op/imm until alu_ready
// S_HALTED | HALT executed; waiting for start
module alu_op_issuer #(
    parameter int PC_W       = 8,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [8:0]       imem_data,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [3:0]       alu_op,
    output logic [4:0]       alu_imm,
    input  logic             alu_zero,
    output logic             busy,
    output logic             halted,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] issued_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_BRZ  = 4'b1101;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic [3:0]       op_q;
    logic [4:0]       imm_q;

    logic [3:0]       dec_op;
    logic [4:0]       dec_imm;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_rel;

    assign dec_op  = imem_data[8:5];
    assign dec_imm = imem_data[4:0];

    // pc arithmetic wraps naturally at PC_W bits; the immediate is two's complement
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_rel = pc_q + PC_W'($signed(dec_imm));

    // Sequencer: fetch/decode/issue FSM with all outputs held in registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            op_q    <= 4'b0000;
            imm_q   <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc_q    <= START_PC;
                        cnt_q   <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    case (dec_op)
                        OP_BRZ: begin
                            pc_q    <= alu_zero ? pc_rel : pc_inc;
                            state_q <= S_FETCH;
                        end
                        OP_JMP: begin
                            pc_q    <= pc_rel;
                            state_q <= S_FETCH;
                        end
                        OP_HALT: begin
                            state_q <= S_HALTED;
                        end
                        default: begin
                            op_q    <= dec_op;
                            imm_q   <= dec_imm;
                            valid_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    endcase
                end
                S_ISSUE: begin
                    if (alu_ready) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_inc;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign issued_count = cnt_q;
    assign alu_valid    = valid_q;
    assign alu_op       = op_q;
    assign alu_imm      = imm_q;
    assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_ISSUE);
    assign halted       = (state_q == S_HALTED);

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: ROM model, scoreboard of expected ALU issues,
// and one task per scenario. Counter width 2 so saturation is reachable.
module tb_alu_op_issuer;

    localparam int PC_W  = 8;
    localparam int CNT_W = 2;

    localparam logic [8:0] I_HALT = 9'b1111_00000;

    typedef struct {
        logic [3:0]      op;
        logic [4:0]      imm;
        logic [PC_W-1:0] pc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic [PC_W-1:0]  imem_addr;
    logic [8:0]       imem_data;
    logic             alu_valid;
    logic             alu_ready;
    logic [3:0]       alu_op;
    logic [4:0]       alu_imm;
    logic             alu_zero;
    logic             busy;
    logic             halted;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] issued_count;

    logic [8:0] rom [256];
    exp_t       sb_q[$];
    int         n_checks;
    int         n_fail;

    alu_op_issuer #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_op       (alu_op),
        .alu_imm      (alu_imm),
        .alu_zero     (alu_zero),
        .busy         (busy),
        .halted       (halted),
        .pc           (pc),
        .issued_count (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous ROM, one-cycle read latency
    always @(posedge clk) imem_data <= rom[imem_addr];

    // scoreboard: every accepted ALU op must match the next expected entry
    always @(negedge clk) begin
        if (!reset && alu_valid && alu_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: op=%h imm=%h pc=%0d issued with nothing expected", alu_op, alu_imm, pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_checks++;
                if (alu_op !== e.op) begin
                    n_fail++;
                    $display("FAIL sb_op: got %h expected %h", alu_op, e.op);
                end
                n_checks++;
                if (alu_imm !== e.imm) begin
                    n_fail++;
                    $display("FAIL sb_imm: got %h expected %h", alu_imm, e.imm);
                end
                n_checks++;
                if (pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL sb_pc: got %0d expected %0d", pc, e.pc);
                end
            end
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = I_HALT;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [4:0] imm, input logic [PC_W-1:0] a);
        exp_t e;
        e.op  = op;
        e.imm = imm;
        e.pc  = a;
        sb_q.push_back(e);
    endtask

    task automatic wait_halted(input int max_cycles);
        int k;
        k = 0;
        while (halted !== 1'b1 && k < max_cycles) begin
            cyc(1);
            k++;
        end
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, max_cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(2);
        n_checks++;
        if ({alu_valid, busy, halted} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: valid/busy/halted=%b required 000", {alu_valid, busy, halted});
        end
        n_checks++;
        if ({alu_op, alu_imm} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_opimm: op=%h imm=%h required 0/0", alu_op, alu_imm);
        end
        n_checks++;
        if (pc !== 8'd0 || imem_addr !== 8'd0 || issued_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_pc_cnt: pc=%0d addr=%0d cnt=%0d required 0/0/0", pc, imem_addr, issued_count);
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_basic_issue();
        clear_rom();
        rom[0] = {4'b0101, 5'd3};
        rom[1] = I_HALT;
        alu_ready = 1'b1;
        push_exp(4'b0101, 5'd3, 8'd0);
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || imem_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL basic_fetch: busy=%b addr=%0d required 1/0", busy, imem_addr);
        end
        cyc(1);
        n_checks++;
        if (alu_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_decode_valid: got %b required 0", alu_valid);
        end
        cyc(1);
        n_checks++;
        if (alu_valid !== 1'b1 || alu_op !== 4'b0101 || alu_imm !== 5'd3) begin
            n_fail++;
            $display("FAIL basic_issue: valid=%b op=%h imm=%h required 1/5/03", alu_valid, alu_op, alu_imm);
        end
        cyc(1);
        n_checks++;
        if (alu_valid !== 1'b0 || pc !== 8'd1 || issued_count !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_after_hs: valid=%b pc=%0d cnt=%0d required 0/1/1", alu_valid, pc, issued_count);
        end
        cyc(2);
        n_checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'd1 || issued_count !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_halted: halted=%b busy=%b pc=%0d cnt=%0d required 1/0/1/1", halted, busy, pc, issued_count);
        end
        n_checks++;
        if (alu_op !== 4'b0101 || alu_imm !== 5'd3) begin
            n_fail++;
            $display("FAIL basic_op_hold: op=%h imm=%h required 5/03", alu_op, alu_imm);
        end
    endtask

    task automatic test_stall();
        clear_rom();
        rom[0] = {4'b0110, 5'd9};
        alu_ready = 1'b0;
        push_exp(4'b0110, 5'd9, 8'd0);
        pulse_start();
        n_checks++;
        if (issued_count !== 2'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_restart: cnt=%0d halted=%b required 0/0", issued_count, halted);
        end
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (alu_valid !== 1'b1 || alu_op !== 4'b0110 || alu_imm !== 5'd9 || pc !== 8'd0 || issued_count !== 2'd0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b op=%h imm=%h pc=%0d cnt=%0d required 1/6/09/0/0",
                         i, alu_valid, alu_op, alu_imm, pc, issued_count);
            end
            cyc(1);
        end
        alu_ready = 1'b1;
        cyc(1);
        n_checks++;
        if (alu_valid !== 1'b0 || pc !== 8'd1 || issued_count !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_accept: valid=%b pc=%0d cnt=%0d required 0/1/1", alu_valid, pc, issued_count);
        end
        wait_halted(10);
    endtask

    task automatic run_brz(input logic zero, input logic [PC_W-1:0] target);
        clear_rom();
        rom[0] = {4'b1110, 5'd4};
        rom[4] = {4'b1101, 5'b11110};
        alu_zero = zero;
        pulse_start();
        cyc(2);
        n_checks++;
        if (imem_addr !== 8'd4) begin
            n_fail++;
            $display("FAIL jmp_fwd: addr=%0d required 4", imem_addr);
        end
        cyc(2);
        n_checks++;
        if (imem_addr !== target || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL brz_zero%0b: addr=%0d busy=%b required %0d/1", zero, imem_addr, busy, target);
        end
        wait_halted(10);
        n_checks++;
        if (pc !== target) begin
            n_fail++;
            $display("FAIL brz_halt_pc: pc=%0d required %0d", pc, target);
        end
    endtask

    task automatic test_brz();
        run_brz(1'b1, 8'd2);
        run_brz(1'b0, 8'd5);
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0]   = {4'b1101, 5'b11111};
        rom[255] = {4'b1110, 5'b00001};
        alu_zero = 1'b1;
        pulse_start();
        cyc(2);
        n_checks++;
        if (imem_addr !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_back: addr=%0d required 255", imem_addr);
        end
        alu_zero = 1'b0;
        cyc(2);
        n_checks++;
        if (pc !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_jmp: pc=%0d required 0", pc);
        end
        wait_halted(10);
        n_checks++;
        if (pc !== 8'd1) begin
            n_fail++;
            $display("FAIL wrap_brz_fall: pc=%0d required 1", pc);
        end

        rom[255] = {4'b1100, 5'd31};
        alu_zero = 1'b1;
        alu_ready = 1'b1;
        push_exp(4'b1100, 5'd31, 8'd255);
        pulse_start();
        cyc(2);
        alu_zero = 1'b0;
        cyc(3);
        n_checks++;
        if (pc !== 8'd0 || issued_count !== 2'd1 || alu_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_issue: pc=%0d cnt=%0d valid=%b required 0/1/0", pc, issued_count, alu_valid);
        end
        wait_halted(10);
    endtask

    task automatic test_reset_in_issue();
        clear_rom();
        rom[0] = {4'b0001, 5'd7};
        rom[1] = {4'b0010, 5'd20};
        alu_ready = 1'b1;
        push_exp(4'b0001, 5'd7, 8'd0);
        pulse_start();
        cyc(3);
        alu_ready = 1'b0;
        cyc(2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        n_checks++;
        if (alu_valid !== 1'b1 || busy !== 1'b1 || pc !== 8'd1 || issued_count !== 2'd1 || alu_op !== 4'b0010) begin
            n_fail++;
            $display("FAIL start_in_issue: valid=%b busy=%b pc=%0d cnt=%0d op=%h required 1/1/1/1/2",
                     alu_valid, busy, pc, issued_count, alu_op);
        end
        reset = 1'b1;
        cyc(1);
        n_checks++;
        if (alu_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || pc !== 8'd0 || issued_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_in_issue: valid=%b busy=%b halted=%b pc=%0d cnt=%0d required 0/0/0/0/0",
                     alu_valid, busy, halted, pc, issued_count);
        end
        reset = 1'b0;
        cyc(2);
        n_checks++;
        if (busy !== 1'b0 || alu_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b valid=%b required 0/0", busy, alu_valid);
        end
    endtask

    task automatic test_saturate();
        clear_rom();
        rom[0] = {4'b0000, 5'd1};
        rom[1] = {4'b0011, 5'd2};
        rom[2] = {4'b1000, 5'd16};
        rom[3] = {4'b1011, 5'd30};
        alu_ready = 1'b1;
        push_exp(4'b0000, 5'd1, 8'd0);
        push_exp(4'b0011, 5'd2, 8'd1);
        push_exp(4'b1000, 5'd16, 8'd2);
        push_exp(4'b1011, 5'd30, 8'd3);
        pulse_start();
        wait_halted(40);
        n_checks++;
        if (issued_count !== 2'd3 || pc !== 8'd4) begin
            n_fail++;
            $display("FAIL saturate: cnt=%0d pc=%0d required 3/4", issued_count, pc);
        end
        alu_ready = 1'b0;
        pulse_start();
        n_checks++;
        if (pc !== 8'd0 || issued_count !== 2'd0 || busy !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_halted: pc=%0d cnt=%0d busy=%b halted=%b required 0/0/1/0",
                     pc, issued_count, busy, halted);
        end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d expected issues never seen, required 0", sb_q.size());
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        alu_ready = 1'b0;
        alu_zero  = 1'b0;
        clear_rom();
        test_reset();
        test_basic_issue();
        test_stall();
        test_brz();
        test_wrap();
        test_reset_in_issue();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
